// File: rtl/ps2_pkg.sv
// Shared types, scan-code set 2 constants and the hex lookup used by the
// PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  // Returns {hit, value}; hit=0 for any code that is not a hex key.
  function automatic logic [4:0] scan_to_hex(input logic [7:0] sc);
    logic [4:0] r;
    r = 5'h00;
    case (sc)
      SC_0: r = {1'b1, 4'h0};
      SC_1: r = {1'b1, 4'h1};
      SC_2: r = {1'b1, 4'h2};
      SC_3: r = {1'b1, 4'h3};
      SC_4: r = {1'b1, 4'h4};
      SC_5: r = {1'b1, 4'h5};
      SC_6: r = {1'b1, 4'h6};
      SC_7: r = {1'b1, 4'h7};
      SC_8: r = {1'b1, 4'h8};
      SC_9: r = {1'b1, 4'h9};
      SC_A: r = {1'b1, 4'hA};
      SC_B: r = {1'b1, 4'hB};
      SC_C: r = {1'b1, 4'hC};
      SC_D: r = {1'b1, 4'hD};
      SC_E: r = {1'b1, 4'hE};
      SC_F: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_rx_frame_rx.sv
// PS/2 physical layer: pin synchronisers, clock glitch filter, 11-bit frame
// deframer with parity/stop checking and a mid-frame inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_ok_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0] pins;
  logic [1:0] synced;
  assign pins = {ps2_data_i, ps2_clk_i};

  // Idle line level is high, so the synchronisers reset to 1 to avoid a false edge.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], pins[gi]};
    end
    assign synced[gi] = sync_q[1];
  end

  logic clk_s, data_s;
  assign clk_s  = synced[0];
  assign data_s = synced[1];

  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FLAST) begin
        filt_d = clk_s;
        fall   = ~clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_ok_q, byte_ok_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    to_cnt_d  = (state_q == IDLE) ? '0 : to_cnt_q + TW'(1);
    byte_ok_d = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (data_s && (^{shift_q, parity_q})) byte_ok_d = 1'b1;
          else                                  err_d     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TLAST) begin
      state_d  = IDLE;
      to_cnt_d = '0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      byte_ok_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      to_cnt_q   <= to_cnt_d;
      byte_ok_q  <= byte_ok_d;
      err_q      <= err_d;
    end
  end

  assign byte_o      = shift_q;
  assign byte_ok_o   = byte_ok_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: scan-code set 2 decode of F0/E0 prefixes, hex
// digits, Enter and Backspace into one-cycle key events.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_enter,
  output logic       key_bksp,
  output logic       frame_err,
  output logic       busy
);

  logic [7:0] rx_byte;
  logic       rx_ok;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_o     (rx_byte),
    .byte_ok_o  (rx_ok),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic       enter_q, enter_d;
  logic       bksp_q, bksp_d;
  logic [4:0] hex_hit;

  assign hex_hit = scan_to_hex(rx_byte);

  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    valid_d = 1'b0;
    code_d  = code_q;
    enter_d = 1'b0;
    bksp_d  = 1'b0;
    if (rx_ok) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        // Prefixed byte (break and/or extended) is swallowed.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (rx_byte == SC_ENTER) begin
        valid_d = 1'b1;
        enter_d = 1'b1;
      end else if (rx_byte == SC_BKSP) begin
        valid_d = 1'b1;
        bksp_d  = 1'b1;
      end else if (hex_hit[4]) begin
        valid_d = 1'b1;
        code_d  = hex_hit[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      enter_q <= 1'b0;
      bksp_q  <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      enter_q <= enter_d;
      bksp_q  <= bksp_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_enter = enter_q;
  assign key_bksp  = bksp_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: frames are bit-banged on the PS/2 pins and
// expected events are queued, then matched as the DUT emits them.
module tb_ps2_key_rx;

  localparam int FL = 4;
  localparam int TO = 2000;
  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid, key_enter, key_bksp, frame_err, busy;
  logic [3:0] key_code;

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_enter(key_enter),
    .key_bksp (key_bksp),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 hex key, 1 enter, 2 backspace, 3 frame error
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] code;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_got, mon_exp;
  int         checks = 0;
  int         errors = 0;
  int         kv_count = 0;
  int         last_kv_cyc = 0;
  logic       brk_m = 1'b0;
  logic       ext_m = 1'b0;
  logic [3:0] last_code = 4'h0;

  function automatic logic [4:0] ref_map(input logic [7:0] b);
    case (b)
      8'h45: return 5'h10;
      8'h16: return 5'h11;
      8'h1E: return 5'h12;
      8'h26: return 5'h13;
      8'h25: return 5'h14;
      8'h2E: return 5'h15;
      8'h36: return 5'h16;
      8'h3D: return 5'h17;
      8'h3E: return 5'h18;
      8'h46: return 5'h19;
      8'h1C: return 5'h1A;
      8'h32: return 5'h1B;
      8'h21: return 5'h1C;
      8'h23: return 5'h1D;
      8'h24: return 5'h1E;
      8'h2B: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && (key_valid || frame_err)) begin
      mon_got.kind = frame_err ? 2'd3 : (key_enter ? 2'd1 : (key_bksp ? 2'd2 : 2'd0));
      mon_got.code = frame_err ? 4'h0 : key_code;
      if (key_valid) begin
        kv_count++;
        last_kv_cyc = cyc;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event at cyc %0d: got kind=%0d code=%h (valid=%b err=%b), required no event",
                 cyc, mon_got.kind, mon_got.code, key_valid, frame_err);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp || (key_valid && frame_err)) begin
          errors++;
          $display("FAIL event_match at cyc %0d: got kind=%0d code=%h (valid=%b err=%b), required kind=%0d code=%h",
                   cyc, mon_got.kind, mon_got.code, key_valid, frame_err, mon_exp.kind, mon_exp.code);
        end else begin
          $display("event ok: cyc %0d kind=%0d code=%h", cyc, mon_got.kind, mon_got.code);
        end
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    logic [4:0] m;
    m = ref_map(b);
    if (b == 8'hF0) brk_m = 1'b1;
    else if (b == 8'hE0) ext_m = 1'b1;
    else if (brk_m || ext_m) begin
      brk_m = 1'b0;
      ext_m = 1'b0;
    end else if (b == 8'h5A) exp_q.push_back({2'd1, last_code});
    else if (b == 8'h66) exp_q.push_back({2'd2, last_code});
    else if (m[4]) begin
      last_code = m[3:0];
      exp_q.push_back({2'd0, m[3:0]});
    end
  endtask

  task automatic ps2_bit(input logic v, output int fall_cyc);
    @(negedge clk);
    ps2_data = v;
    repeat (HP) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par, input logic stp, output int stop_fall);
    int f;
    ps2_bit(1'b0, f);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], f);
    ps2_bit(par, f);
    ps2_bit(stp, stop_fall);
    repeat (HP) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    int f;
    expect_byte(b);
    send_raw(b, ~^b, 1'b1, f);
    $display("frame sent: %h", b);
  endtask

  task automatic check_drained(input string name);
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_valid, key_code, key_enter, key_bksp, frame_err, busy} !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {key_valid, key_code, key_enter, key_bksp, frame_err, busy});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    int f;
    int kv0;
    kv0 = kv_count;
    expect_byte(8'h1E);
    send_raw(8'h1E, 1'b1, 1'b1, f);
    checks++;
    if (kv_count - kv0 != 1) begin
      errors++;
      $display("FAIL basic_count: got %0d key_valid pulses, required 1", kv_count - kv0);
    end
    checks++;
    if (last_kv_cyc != f + 7) begin
      errors++;
      $display("FAIL basic_latency: key_valid at cyc %0d, required %0d", last_kv_cyc, f + 7);
    end
    check_drained("basic");
  endtask

  task automatic test_prefix();
    send_good(8'hF0);
    send_good(8'h1E);
    send_good(8'h2B);
    send_good(8'hE0);
    send_good(8'h5A);
    send_good(8'h5A);
    send_good(8'h66);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h16);
    send_good(8'h77);
    check_drained("prefix");
  endtask

  task automatic test_errors();
    int f;
    exp_q.push_back({2'd3, 4'h0});
    send_raw(8'h1E, 1'b0, 1'b1, f);
    exp_q.push_back({2'd3, 4'h0});
    send_raw(8'h1E, 1'b1, 1'b0, f);
    send_good(8'h45);
    check_drained("errors");
  endtask

  task automatic test_timeout();
    int         f;
    int         t0;
    bit         seen;
    logic [7:0] v;
    v = 8'h3D;
    t0 = 0;
    exp_q.push_back({2'd3, 4'h0});
    ps2_bit(1'b0, f);
    for (int i = 0; i < 4; i++) ps2_bit(v[i], f);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy_mid: got %b, required 1", busy);
    end
    seen = 1'b0;
    for (int k = 0; k < TO + 100 && !seen; k++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = 1'b1;
        t0   = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_err: no frame_err within %0d cycles, required at cyc %0d", TO + 100, f + 6 + TO);
    end else if (t0 != f + 6 + TO) begin
      errors++;
      $display("FAIL timeout_err: frame_err at cyc %0d, required %0d", t0, f + 6 + TO);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy_after: got %b, required 0", busy);
    end
    send_good(8'h3D);
    check_drained("timeout");
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL glitch_busy %0d: got %b, required 0", g, busy);
      end
    end
    check_drained("glitch");
  endtask

  task automatic test_reset_mid();
    int f;
    send_good(8'h46);
    ps2_bit(1'b0, f);
    ps2_bit(1'b1, f);
    ps2_bit(1'b0, f);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b, required 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    brk_m = 1'b0;
    ext_m = 1'b0;
    last_code = 4'h0;
    checks++;
    if ({key_valid, key_code, key_enter, key_bksp, frame_err, busy} !== 9'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b, required 000000000",
               {key_valid, key_code, key_enter, key_bksp, frame_err, busy});
    end
    repeat (10) @(negedge clk);
    send_good(8'h5A);
    send_good(8'h26);
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    send_good(8'h16);
    send_good(8'h16);
    send_good(8'h16);
    send_good(8'h66);
    send_good(8'h1C);
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #60000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
PS/2 keyboard receiver that sits upstream of the keyboard cache and feeds the CPU's key-data IO path. It synchronises and filters the raw ps2_clk/ps2_data pins and deframes 11-bit PS/2 frames. It decodes scan-code set 2, including the F0 break and E0 extended prefixes, and emits one-cycle key events for hex digits 0-F, Enter and Backspace. All logic runs in the CPU clock domain.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered clock changes level
TIMEOUT_CYCLES, 20000, clk cycles without a falling edge mid-frame before the frame is abandoned

Ports:
clk  input  1  CPU clock
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
key_valid  output  1  one-cycle pulse: mapped make code received
key_code  output  4  hex value 0-F; valid with key_valid, held until the next event
key_enter  output  1  qualifies key_valid: Enter key
key_bksp  output  1  qualifies key_valid: Backspace key
frame_err  output  1  one-cycle pulse: parity, stop or timeout error
busy  output  1  high while a frame is in progress (FSM not in IDLE)

Behaviour:
- Reset (synchronous): one clk cycle with rst=1.
  - All outputs return to 0.
  - FSM goes to IDLE; break_pending and ext_pending clear; shift register, bit counter, timeout counter and filter clear.
  - The filtered clock is forced to 1.
  - Reset mid-frame abandons the frame silently, with no frame_err.
- Synchronisers: 2-FF synchronisers on both pins.
- Clock filter:
  - The filtered clock changes only after FILTER_LEN consecutive identical synchronised samples.
  - A falling edge is a filtered 1->0 transition, flagged for one cycle.
  - ps2_data is sampled from its synchroniser output on that same cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
- FSM states and transitions (all advance on a falling edge):
  - IDLE: a sampled 0 moves to DATA with bit_cnt=0. A sampled 1 is a spurious start; stay in IDLE with no error.
  - DATA: shift the sampled bit into bit [7]. Increment bit_cnt; after the 8th bit go to PARITY.
  - PARITY: store the sampled bit and go to STOP.
  - STOP: if the stop bit is 1 and XOR(data, parity)=1, the byte is good. Otherwise pulse frame_err on the next cycle. Either way return to IDLE.
- Timeout:
  - The timeout counter resets on every falling edge and counts while not in IDLE.
  - Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE and pulses frame_err.
  - Prefix flags are kept.
- Scan-code decode: runs one cycle after a good byte, so key_valid fires two cycles after the stop-bit falling edge is detected.
  - F0: set break_pending; no output.
  - E0: set ext_pending; no output.
  - Any other byte with break_pending or ext_pending set: clear both flags; no output. This means E0 F0 xx, F0 xx and E0 xx produce nothing.
  - Otherwise, look up the make code:
    - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
    - Hex letters: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
    - 5A: Enter; pulse key_valid and key_enter, key_code unchanged.
    - 66: Backspace; pulse key_valid and key_bksp, key_code unchanged.
    - Unmapped code: no output.
  - Typematic repeats of a make code each produce a key_valid pulse.
- Simultaneous events: frame_err and key_valid cannot coincide; a single frame yields at most one of the two.
- Bad bytes never touch the prefix flags.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, and the 16 hex make codes.
  - Function scan_to_hex returning {hit, value[3:0]}.
- Sub-module ps2_frame_rx covers synchronisers, filter, FSM and timeout.
  - Outputs: byte[7:0], byte_ok pulse, frame_err pulse, busy.
- Top level ps2_key_rx holds the prefix flags, decode and output registers.

Test Plan:
- Frame 0x1E (data 0,1,1,1,1,0,0,0 LSB first, parity 1, stop 1) at a 40 us PS/2 period -> exactly one key_valid with key_code=2; key_enter=0; frame_err stays 0.
- F0 then 1E -> no key_valid. A following 0x2B frame -> key_valid, key_code=F.
- E0 then 5A -> no output. 0x5A alone -> key_valid with key_enter=1. 0x66 -> key_valid with key_bksp=1.
- 0x1E frame with parity bit 0 -> frame_err pulse, no key_valid. 0x1E frame with stop bit 0 -> same. A following good 0x45 frame -> key_code=0.
- Stop clocking after 4 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last falling edge; busy drops; the next full frame decodes correctly.
- 2-cycle low glitches on ps2_clk while idle -> busy stays 0 and no events. Assert rst mid-frame -> all outputs 0, no frame_err; the next frame decodes correctly.
